token_precision_assign: RTL and testbench

- Computes the per-token precision codes consumed by attention_av_multiply (token_precision input), derived from the attention weight matrix A.
- For each key token l2, sums the attention it receives over all query rows l and heads n, then classifies that column sum against two thresholds into INT4 / INT8 / full codes.
- Sits directly upstream of the AV multiply and shares its A_in layout, so the same A bus can fan out to both blocks.
- Multi-cycle: processes one query row per cycle.

---
 rtl/token_precision_assign.sv | 129 ++++++++++++
 tb/tb_token_precision_assign.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/token_precision_assign.sv
// Per-token precision classifier: sums attention received by each key token
// over all query rows and heads, then buckets each column sum into INT4/INT8/full.
module token_precision_assign #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned L          = 8,
    parameter int unsigned N          = 1,
    parameter logic [15:0] THR_LO     = 16'h0100,
    parameter logic [15:0] THR_HI     = 16'h0400,
    localparam int unsigned SW        = DATA_WIDTH + $clog2(L * N) + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [DATA_WIDTH*L*N*L-1:0]  A_in,
    output logic                         done,
    output logic [3:0]                   token_precision [L-1:0],
    output logic [SW*L-1:0]              col_sum_out
);

    localparam int unsigned RW = (L > 1) ? $clog2(L) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ACCUM,
        S_CLASSIFY,
        S_DONE
    } state_e;

    state_e                  state_q;
    logic                    done_q;
    logic [3:0]              tp_q       [L-1:0];
    logic [SW*L-1:0]         col_out_q;
    logic [SW-1:0]           col_sum_q  [L-1:0];
    logic [RW-1:0]           row_cnt_q;
    logic [DATA_WIDTH-1:0]   a_q        [L-1:0][N-1:0][L-1:0];
    logic [SW-1:0]           row_sum_c  [L-1:0];

    // Sum of the current query row across heads, per key column.
    always_comb begin
        for (int unsigned c = 0; c < L; c++) begin
            row_sum_c[c] = '0;
            for (int unsigned h = 0; h < N; h++) begin
                row_sum_c[c] = row_sum_c[c] + SW'(a_q[row_cnt_q][h][c]);
            end
        end
    end

    function automatic logic [3:0] classify(input logic [SW-1:0] s);
        if (s < SW'(THR_LO)) begin
            return 4'd0;
        end
        if (s < SW'(THR_HI)) begin
            return 4'd1;
        end
        return 4'd2;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            done_q    <= 1'b0;
            col_out_q <= '0;
            row_cnt_q <= '0;
            for (int unsigned c = 0; c < L; c++) begin
                tp_q[c]      <= 4'd2;
                col_sum_q[c] <= '0;
            end
            for (int unsigned r = 0; r < L; r++) begin
                for (int unsigned h = 0; h < N; h++) begin
                    for (int unsigned c = 0; c < L; c++) begin
                        a_q[r][h][c] <= '0;
                    end
                end
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    for (int unsigned r = 0; r < L; r++) begin
                        for (int unsigned h = 0; h < N; h++) begin
                            for (int unsigned c = 0; c < L; c++) begin
                                a_q[r][h][c] <= A_in[((r*N*L) + (h*L) + c)*DATA_WIDTH +: DATA_WIDTH];
                            end
                        end
                    end
                    for (int unsigned c = 0; c < L; c++) begin
                        col_sum_q[c] <= '0;
                    end
                    row_cnt_q <= '0;
                    state_q   <= S_ACCUM;
                end
                S_ACCUM: begin
                    for (int unsigned c = 0; c < L; c++) begin
                        col_sum_q[c] <= col_sum_q[c] + row_sum_c[c];
                    end
                    row_cnt_q <= row_cnt_q + RW'(1);
                    if (row_cnt_q == RW'(L - 1)) begin
                        state_q <= S_CLASSIFY;
                    end
                end
                S_CLASSIFY: begin
                    for (int unsigned c = 0; c < L; c++) begin
                        tp_q[c]                <= classify(col_sum_q[c]);
                        col_out_q[c*SW +: SW]  <= col_sum_q[c];
                    end
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign done            = done_q;
    assign token_precision = tp_q;
    assign col_sum_out     = col_out_q;

endmodule

// File: tb/tb_token_precision_assign.sv
// Directed + randomized bench for token_precision_assign against a column-sum reference model.
module tb_token_precision_assign;

    localparam int unsigned DW = 16;
    localparam int unsigned L  = 8;
    localparam int unsigned N  = 1;
    localparam int unsigned SW = DW + $clog2(L * N) + 1;
    localparam int unsigned AW = DW * L * N * L;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [AW-1:0]   A_in;
    logic            done;
    logic [3:0]      token_precision [L-1:0];
    logic [SW*L-1:0] col_sum_out;

    int unsigned a_m [L][N][L];
    int unsigned exp_sum [L];
    int unsigned exp_code [L];
    int n_assert = 0;
    int n_fail   = 0;

    token_precision_assign #(
        .DATA_WIDTH(DW), .L(L), .N(N), .THR_LO(16'h0100), .THR_HI(16'h0400)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .A_in(A_in),
        .done(done), .token_precision(token_precision), .col_sum_out(col_sum_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pack_a();
        for (int l = 0; l < L; l++)
            for (int n = 0; n < N; n++)
                for (int c = 0; c < L; c++)
                    A_in[((l*N*L) + (n*L) + c)*DW +: DW] = DW'(a_m[l][n][c]);
    endtask

    task automatic fill_const(input int unsigned v);
        for (int l = 0; l < L; l++)
            for (int n = 0; n < N; n++)
                for (int c = 0; c < L; c++)
                    a_m[l][n][c] = v;
        pack_a();
    endtask

    task automatic fill_rand(input int unsigned mask);
        for (int l = 0; l < L; l++)
            for (int n = 0; n < N; n++)
                for (int c = 0; c < L; c++)
                    a_m[l][n][c] = $urandom & mask;
        pack_a();
    endtask

    // Reference: column sum over every row and head, then bucket by thresholds.
    task automatic compute_expected();
        for (int c = 0; c < L; c++) begin
            exp_sum[c] = 0;
            for (int l = 0; l < L; l++)
                for (int n = 0; n < N; n++)
                    exp_sum[c] += a_m[l][n][c];
            exp_code[c] = (exp_sum[c] < 32'h100) ? 0 : (exp_sum[c] < 32'h400) ? 1 : 2;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " done"}, 32'(done), 32'd0);
        for (int c = 0; c < L; c++) begin
            check({tag, " code"}, 32'(token_precision[c]), 32'd2);
            check({tag, " sum"}, 32'(col_sum_out[c*SW +: SW]), 32'd0);
        end
    endtask

    task automatic check_outputs(input string tag);
        for (int c = 0; c < L; c++) begin
            check({tag, " code"}, 32'(token_precision[c]), exp_code[c]);
            check({tag, " sum"}, 32'(col_sum_out[c*SW +: SW]), exp_sum[c]);
        end
    endtask

    // Pulse start, expect done exactly at E10, then verify outputs and a single pulse.
    task automatic run_check(input string tag, input bit disturb, input bit start_in_done);
        int k;
        int extra;
        compute_expected();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (done !== 1'b1 && k < 30) begin
            @(posedge clk); #1;
            k++;
            if (disturb && k == 1)
                for (int i = 0; i < AW / 32; i++) A_in[i*32 +: 32] = $urandom;
            if (disturb && k == 2) start = 1'b1;
            if (disturb && k == 3) start = 1'b0;
        end
        check({tag, " latency"}, 32'(k), 32'd10);
        check_outputs(tag);
        if (start_in_done) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, " done_pulse"}, 32'(done), 32'd0);
        extra = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done === 1'b1) extra++;
        end
        check({tag, " no_extra_done"}, 32'(extra), 32'd0);
        check_outputs({tag, " hold"});
    endtask

    initial begin
        int seen;
        rst   = 1'b1;
        start = 1'b0;
        A_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst = 1'b0;
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done !== 1'b0) seen++;
        end
        check("idle_no_done", 32'(seen), 32'd0);
        check_reset_vals("idle_hold");

        fill_const(0);
        run_check("zero", 1'b0, 1'b0);

        fill_const(32'h0020);
        run_check("eq_lo", 1'b0, 1'b0);
        fill_const(32'h0080);
        run_check("eq_hi", 1'b0, 1'b1);

        fill_const(0);
        a_m[0][0][0] = 32'h00FF;
        a_m[0][0][1] = 32'h0080;
        a_m[1][0][1] = 32'h0080;
        for (int l = 0; l < 3; l++) a_m[l][0][2] = 32'h0155;
        for (int l = 0; l < L; l++) a_m[l][0][3] = 32'h0080;
        pack_a();
        run_check("mixed", 1'b0, 1'b0);

        fill_const(32'hFFFF);
        run_check("max_disturb", 1'b1, 1'b0);

        for (int t = 0; t < 4; t++) begin
            fill_rand(32'h00FF);
            run_check("rand_small", 1'b0, 1'b0);
        end
        fill_rand(32'hFFFF);
        run_check("rand_full", 1'b0, 1'b0);

        fill_rand(32'h00FF);
        run_check("pre_abort", 1'b0, 1'b0);
        fill_rand(32'h00FF);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset_vals("abort");
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done !== 1'b0) seen++;
        end
        check("abort_no_done", 32'(seen), 32'd0);
        check_reset_vals("abort_hold");
        run_check("after_abort", 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
